load_store_unit: RTL and testbench

Load/store initiator between the MIPS datapath and the `data_memory` word array: 13-bit word index, 32-bit data, combinational read while `memread` is high, write at `posedge clk` while `memwrite` is high. It accepts byte-addressed LW/LH/LHU/LB/LBU/SW/SH/SB requests from the core and converts them into word-level memory cycles. Sub-word loads are aligned and extended. Sub-word stores use a read-modify-write sequence.

---
 rtl/load_store_unit_if.sv | 33 +++
 rtl/load_store_unit.sv | 155 +++++++++++++++
 tb/tb_load_store_unit.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Core/memory bus bundle for the load/store unit.
// Request/response handshake on one side, word memory port on the other.
interface load_store_unit_if #(
    parameter int ADDR_W = 13
);
    logic              req;
    logic              we;
    logic [1:0]        size;
    logic              sign_ext;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic              ready;
    logic              done;
    logic              err;
    logic [31:0]       rdata;
    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_write_data;
    logic              mem_memread;
    logic              mem_memwrite;
    logic [31:0]       mem_read_data;

    modport slave (
        input  req, we, size, sign_ext, addr, wdata, mem_read_data,
        output ready, done, err, rdata,
        output mem_address, mem_write_data, mem_memread, mem_memwrite
    );

    modport master (
        output req, we, size, sign_ext, addr, wdata, mem_read_data,
        input  ready, done, err, rdata,
        input  mem_address, mem_write_data, mem_memread, mem_memwrite
    );
endinterface

// File: rtl/load_store_unit.sv
// Byte-addressed load/store initiator over a word-wide memory.
// Big-endian lanes; sub-word stores use read-modify-write.
module load_store_unit #(
    parameter int ADDR_W = 13
) (
    input  logic               clk,
    input  logic               reset,
    load_store_unit_if.slave   bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_RMW_RD,
        S_RMW_WR,
        S_RESP
    } state_t;

    state_t      st;
    logic [1:0]  r_size;
    logic [1:0]  r_off;
    logic        r_sext;
    logic [15:0] r_wdata;

    logic        misalign;
    logic [4:0]  bsh;
    logic [4:0]  hsh;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] lane;
    logic [31:0] mask;
    logic [31:0] ins;
    logic [31:0] merged;
    logic        unused_hi;

    assign unused_hi = ^bus.addr[31:ADDR_W+2];

    // Reject illegal size or an address not aligned to the access size.
    always_comb begin
        misalign = 1'b0;
        unique case (bus.size)
            2'b00: misalign = 1'b0;
            2'b01: misalign = bus.addr[0];
            2'b10: misalign = |bus.addr[1:0];
            default: misalign = 1'b1;
        endcase
    end

    // Pick the addressed lane out of the read word and extend it.
    always_comb begin
        bsh    = {~r_off, 3'b000};
        hsh    = r_off[1] ? 5'd0 : 5'd16;
        byte_v = 8'(bus.mem_read_data >> bsh);
        half_v = r_off[1] ? bus.mem_read_data[15:0]
                          : bus.mem_read_data[31:16];
        unique case (r_size)
            2'b00:   lane = r_sext ? {{24{byte_v[7]}}, byte_v}
                                   : {24'h0, byte_v};
            2'b01:   lane = r_sext ? {{16{half_v[15]}}, half_v}
                                   : {16'h0, half_v};
            default: lane = bus.mem_read_data;
        endcase
    end

    // Replace the target lane of the read word with the store data.
    always_comb begin
        if (r_size == 2'b00) begin
            mask = 32'h0000_00ff << bsh;
            ins  = {24'h0, r_wdata[7:0]} << bsh;
        end else begin
            mask = 32'h0000_ffff << hsh;
            ins  = {16'h0, r_wdata} << hsh;
        end
        merged = (bus.mem_read_data & ~mask) | ins;
    end

    // Control FSM; every output is a registered function of the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            st                 <= S_IDLE;
            bus.ready          <= 1'b1;
            bus.done           <= 1'b0;
            bus.err            <= 1'b0;
            bus.rdata          <= '0;
            bus.mem_address    <= '0;
            bus.mem_write_data <= '0;
            bus.mem_memread    <= 1'b0;
            bus.mem_memwrite   <= 1'b0;
            r_size             <= '0;
            r_off              <= '0;
            r_sext             <= 1'b0;
            r_wdata            <= '0;
        end else begin
            bus.ready        <= 1'b0;
            bus.done         <= 1'b0;
            bus.err          <= 1'b0;
            bus.mem_memread  <= 1'b0;
            bus.mem_memwrite <= 1'b0;
            unique case (st)
                S_IDLE: begin
                    bus.ready <= 1'b1;
                    if (bus.req) begin
                        bus.ready       <= 1'b0;
                        r_size          <= bus.size;
                        r_off           <= bus.addr[1:0];
                        r_sext          <= bus.sign_ext;
                        r_wdata         <= bus.wdata[15:0];
                        bus.mem_address <= bus.addr[ADDR_W+1:2];
                        if (misalign) begin
                            st       <= S_RESP;
                            bus.done <= 1'b1;
                            bus.err  <= 1'b1;
                        end else if (!bus.we) begin
                            st              <= S_LOAD;
                            bus.mem_memread <= 1'b1;
                        end else if (bus.size == 2'b10) begin
                            st                 <= S_WRITE;
                            bus.mem_memwrite   <= 1'b1;
                            bus.mem_write_data <= bus.wdata;
                        end else begin
                            st              <= S_RMW_RD;
                            bus.mem_memread <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    bus.rdata <= lane;
                    st        <= S_RESP;
                    bus.done  <= 1'b1;
                end
                S_WRITE: begin
                    st       <= S_RESP;
                    bus.done <= 1'b1;
                end
                S_RMW_RD: begin
                    bus.mem_write_data <= merged;
                    bus.mem_memwrite   <= 1'b1;
                    st                 <= S_RMW_WR;
                end
                S_RMW_WR: begin
                    st       <= S_RESP;
                    bus.done <= 1'b1;
                end
                S_RESP: begin
                    st        <= S_IDLE;
                    bus.ready <= 1'b1;
                end
                default: begin
                    st        <= S_IDLE;
                    bus.ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a byte-array memory model.
// Directed cases followed by randomized load/store traffic.
module tb_load_store_unit;
    localparam int ADDR_W = 13;
    localparam int NWORDS = 1 << ADDR_W;

    logic clk = 1'b0;
    logic reset = 1'b1;

    load_store_unit_if #(.ADDR_W(ADDR_W)) bus ();

    load_store_unit #(.ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              err;
        logic [31:0]       rdata;
        int                lat;
        int                acc;
        int                nrd;
        int                nwr;
        logic [ADDR_W-1:0] widx;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] mem [0:NWORDS-1];
    logic [7:0]  rb  [0:4*NWORDS-1];
    logic [31:0] held;
    int cyc = 0;
    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int rd_base = 0;
    int wr_base = 0;

    function automatic logic [31:0] init_word(int i);
        if (i == 5) return 32'h8899_AABB;
        return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    // Word memory: combinational read, write on the rising edge.
    assign bus.mem_read_data = bus.mem_memread ? mem[bus.mem_address] : 32'h0;

    initial begin
        for (int i = 0; i < NWORDS; i++) mem[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (bus.mem_memwrite) mem[bus.mem_address] = bus.mem_write_data;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] got, logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Reference model on a big-endian byte array.
    task automatic predict(input logic w, input logic [1:0] sz,
                           input logic sx, input logic [31:0] ad,
                           input logic [31:0] wd, output exp_t e);
        int a;
        logic [31:0] v;
        a = int'(ad[ADDR_W+1:0]);
        e.widx = ad[ADDR_W+1:2];
        e.acc = 0;
        e.err = 1'b0;
        e.nrd = 0;
        e.nwr = 0;
        if (sz == 2'd3 || (sz == 2'd1 && a % 2 != 0) ||
            (sz == 2'd2 && a % 4 != 0)) begin
            e.err = 1'b1;
            e.lat = 1;
        end else if (!w) begin
            if (sz == 2'd0)
                v = sx ? {{24{rb[a][7]}}, rb[a]} : {24'h0, rb[a]};
            else if (sz == 2'd1)
                v = sx ? {{16{rb[a][7]}}, rb[a], rb[a+1]}
                       : {16'h0, rb[a], rb[a+1]};
            else
                v = {rb[a], rb[a+1], rb[a+2], rb[a+3]};
            held = v;
            e.lat = 2;
            e.nrd = 1;
        end else if (sz == 2'd2) begin
            rb[a]   = wd[31:24];
            rb[a+1] = wd[23:16];
            rb[a+2] = wd[15:8];
            rb[a+3] = wd[7:0];
            e.lat = 2;
            e.nwr = 1;
        end else begin
            if (sz == 2'd1) begin
                rb[a]   = wd[15:8];
                rb[a+1] = wd[7:0];
            end else begin
                rb[a] = wd[7:0];
            end
            e.lat = 3;
            e.nrd = 1;
            e.nwr = 1;
        end
        e.rdata = held;
    endtask

    task automatic scramble();
        bus.we       = 1'($urandom);
        bus.size     = 2'($urandom);
        bus.sign_ext = 1'($urandom);
        bus.addr     = $urandom;
        bus.wdata    = $urandom;
    endtask

    task automatic issue(input logic w, input logic [1:0] sz,
                         input logic sx, input logic [31:0] ad,
                         input logic [31:0] wd);
        exp_t e;
        int n = 0;
        while (!bus.ready) begin
            @(negedge clk);
            n++;
            if (n > 50) begin
                tests++;
                fails++;
                $display("FAIL ready_timeout: got 0 expected 1");
                return;
            end
        end
        bus.req      = 1'b1;
        bus.we       = w;
        bus.size     = sz;
        bus.sign_ext = sx;
        bus.addr     = ad;
        bus.wdata    = wd;
        predict(w, sz, sx, ad, wd, e);
        e.acc = cyc + 1;
        sbq.push_back(e);
        @(negedge clk);
        bus.req = 1'b0;
        scramble();
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sbq.size() != 0 || !bus.ready) begin
            @(negedge clk);
            n++;
            if (n > 50) begin
                tests++;
                fails++;
                $display("FAIL idle_timeout: got %0d pending expected 0",
                         sbq.size());
                return;
            end
        end
    endtask

    task automatic chk_reset_vals(string tag);
        chk({tag, "_ready"}, 32'(bus.ready), 32'd1);
        chk({tag, "_done"}, 32'(bus.done), 32'd0);
        chk({tag, "_err"}, 32'(bus.err), 32'd0);
        chk({tag, "_rdata"}, bus.rdata, 32'd0);
        chk({tag, "_maddr"}, 32'(bus.mem_address), 32'd0);
        chk({tag, "_mwdata"}, bus.mem_write_data, 32'd0);
        chk({tag, "_mrd"}, 32'(bus.mem_memread), 32'd0);
        chk({tag, "_mwr"}, 32'(bus.mem_memwrite), 32'd0);
    endtask

    // Monitor: pops the scoreboard on every done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (bus.mem_memread) rd_cnt++;
        if (bus.mem_memwrite) wr_cnt++;
        if (bus.mem_memread && bus.mem_memwrite) begin
            tests++;
            fails++;
            $display("FAIL rd_wr_overlap: got both high expected exclusive");
        end
        if ((bus.mem_memread || bus.mem_memwrite) && sbq.size() > 0)
            chk("mem_address", 32'(bus.mem_address), 32'(sbq[0].widx));
        if (!reset && bus.done) begin
            done_cnt++;
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done expected none");
            end else begin
                e = sbq.pop_front();
                chk("err", 32'(bus.err), 32'(e.err));
                chk("rdata", bus.rdata, e.rdata);
                chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
                chk("mem_reads", 32'(rd_cnt - rd_base), 32'(e.nrd));
                chk("mem_writes", 32'(wr_cnt - wr_base), 32'(e.nwr));
            end
        end
        if (sbq.size() == 0) begin
            rd_base = rd_cnt;
            wr_base = wr_cnt;
        end
    end

    initial begin
        int dc;
        int acc;
        int n;
        logic [31:0] ad;
        bus.req = 1'b0;
        scramble();
        held = 32'h0;
        for (int i = 0; i < NWORDS; i++) begin
            ad = init_word(i);
            rb[4*i]   = ad[31:24];
            rb[4*i+1] = ad[23:16];
            rb[4*i+2] = ad[15:8];
            rb[4*i+3] = ad[7:0];
        end

        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        reset = 1'b0;
        @(negedge clk);

        issue(1'b0, 2'd0, 1'b1, 32'h15, 32'h0);
        wait_idle();
        chk("lb_sext", bus.rdata, 32'hFFFF_FF99);
        issue(1'b0, 2'd0, 1'b0, 32'h15, 32'h0);
        wait_idle();
        chk("lbu", bus.rdata, 32'h0000_0099);
        issue(1'b1, 2'd2, 1'b0, 32'h20, 32'hDEAD_BEEF);
        wait_idle();
        chk("sw_mem", mem[8], 32'hDEAD_BEEF);
        issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
        wait_idle();
        chk("lw", bus.rdata, 32'hDEAD_BEEF);
        issue(1'b1, 2'd1, 1'b0, 32'h22, 32'h0000_1234);
        wait_idle();
        chk("sh_mem", mem[8], 32'hDEAD_1234);
        issue(1'b0, 2'd1, 1'b1, 32'h20, 32'h0);
        wait_idle();
        chk("lh_sext", bus.rdata, 32'hFFFF_DEAD);
        issue(1'b0, 2'd2, 1'b0, 32'h21, 32'h0);
        issue(1'b1, 2'd1, 1'b0, 32'h23, 32'h0);
        wait_idle();
        chk("err_rdata_held", bus.rdata, 32'hFFFF_DEAD);

        bus.req      = 1'b1;
        bus.we       = 1'b1;
        bus.size     = 2'd0;
        bus.sign_ext = 1'b0;
        bus.addr     = 32'h31;
        bus.wdata    = 32'h77;
        @(negedge clk);
        bus.req = 1'b0;
        chk("rmw_rd_active", 32'(bus.mem_memread), 32'd1);
        dc = done_cnt;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        held = 32'h0;
        chk_reset_vals("abort");
        repeat (3) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt - dc), 32'd0);
        chk("abort_no_write", mem[12], init_word(12));
        issue(1'b0, 2'd2, 1'b0, 32'h30, 32'h0);
        wait_idle();
        chk("after_abort_lw", bus.rdata, init_word(12));

        bus.req = 1'b1;
        reset = 1'b1;
        bus.we = 1'b0;
        bus.size = 2'd2;
        bus.addr = 32'h40;
        @(negedge clk);
        bus.req = 1'b0;
        reset = 1'b0;
        held = 32'h0;
        dc = done_cnt;
        repeat (4) @(negedge clk);
        chk("req_rst_dropped", 32'(done_cnt - dc), 32'd0);
        chk("req_rst_ready", 32'(bus.ready), 32'd1);

        acc = 0;
        n = 0;
        dc = done_cnt;
        bus.req = 1'b1;
        while (acc < 10 && n < 200) begin
            if (bus.ready) begin
                exp_t e;
                bus.we       = 1'(acc % 2);
                bus.size     = 2'd2;
                bus.sign_ext = 1'b0;
                bus.addr     = 32'($urandom_range(0, 31)) << 2;
                bus.wdata    = $urandom;
                predict(bus.we, bus.size, bus.sign_ext, bus.addr,
                        bus.wdata, e);
                e.acc = cyc + 1;
                sbq.push_back(e);
                acc++;
            end else begin
                scramble();
            end
            @(negedge clk);
            n++;
        end
        bus.req = 1'b0;
        wait_idle();
        chk("held_req_accepts", 32'(acc), 32'd10);
        chk("held_req_dones", 32'(done_cnt - dc), 32'(acc));

        repeat (150) begin
            ad = ($urandom & 32'hFFFF_8000) |
                 (32'($urandom_range(0, 31)) << 2) |
                 32'($urandom_range(0, 3));
            issue(1'($urandom), 2'($urandom), 1'($urandom), ad, $urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_idle();

        for (int i = 0; i < 32; i++)
            chk("final_mem", mem[i],
                {rb[4*i], rb[4*i+1], rb[4*i+2], rb[4*i+3]});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
